// File: rtl/dataflow_pkg.sv
// -----------------------------------------------------------------------------
// dataflow_pkg
// Shared helpers for the dataflow blocks.
//   clog2     : ceiling log2 of a positive integer, usable in constant context
//   tag_width : width of a source-index tag for n requesters, never below 1
// -----------------------------------------------------------------------------
package dataflow_pkg;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 << i) < value) begin
        result = i + 1;
      end else begin
        result = result;
      end
    end
    return result;
  endfunction

  // A single requester still needs a 1-bit tag so ports never collapse to zero width.
  function automatic int tag_width(input int n);
    return (clog2(n) < 1) ? 1 : clog2(n);
  endfunction

endpackage

// File: rtl/dataflow_rr_select.sv
// -----------------------------------------------------------------------------
// dataflow_rr_select
// Combinational round-robin selector. Rotates the request vector so that the
// requester after last_grant_i sits at position 0, picks the lowest set bit,
// and maps that position back to an absolute requester index.
// Ports:
//   req_i        [N-1:0]   request vector
//   last_grant_i [TW-1:0]  most recently granted index (must be < N)
//   grant_o      [TW-1:0]  selected index, valid only when any_req_o=1
//   any_req_o              at least one request is set
// -----------------------------------------------------------------------------
module dataflow_rr_select #(
  parameter int N  = 2,
  parameter int TW = 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [TW-1:0] last_grant_i,
  output logic [TW-1:0] grant_o,
  output logic          any_req_o
);

  logic [N-1:0] rot_s;
  int           start_s;
  int           pos_s;
  logic         found_s;

  // Rotate, priority-encode the rotated vector, then un-rotate the winner.
  always_comb begin
    rot_s   = '0;
    pos_s   = 0;
    found_s = 1'b0;
    start_s = (int'(last_grant_i) + 1) % N;
    for (int j = 0; j < N; j++) begin
      rot_s[j] = req_i[(start_s + j) % N];
    end
    for (int j = 0; j < N; j++) begin
      if (!found_s && rot_s[j]) begin
        found_s = 1'b1;
        pos_s   = j;
      end else begin
        found_s = found_s;
      end
    end
    grant_o   = TW'((start_s + pos_s) % N);
    any_req_o = found_s;
  end

endmodule

// File: rtl/dataflow_rr_merge.sv
// -----------------------------------------------------------------------------
// dataflow_rr_merge
// N-to-1 valid/ready merge with round-robin arbitration and one registered
// output stage. Each output beat carries the index of its source requester.
// Ports:
//   clk                         rising-edge clock
//   reset                       synchronous, active-high
//   i_valid [NUM_INPUTS]        per-requester valid
//   i_ready [NUM_INPUTS]        per-requester ready, one-hot or zero
//   i_data  [NUM_INPUTS*DW]     requester k at [k*DW +: DW]
//   o_valid                     output register holds a beat
//   o_ready                     downstream accept
//   o_data  [DW]                registered payload
//   o_tag   [TAG_WIDTH]         source index of o_data
// -----------------------------------------------------------------------------
module dataflow_rr_merge
  import dataflow_pkg::*;
#(
  parameter  int NUM_INPUTS = 2,
  parameter  int DATA_WIDTH = 32,
  localparam int TAG_WIDTH  = tag_width(NUM_INPUTS)
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [NUM_INPUTS-1:0]            i_valid,
  output logic [NUM_INPUTS-1:0]            i_ready,
  input  logic [NUM_INPUTS*DATA_WIDTH-1:0] i_data,
  output logic                             o_valid,
  input  logic                             o_ready,
  output logic [DATA_WIDTH-1:0]            o_data,
  output logic [TAG_WIDTH-1:0]             o_tag
);

  logic                  o_valid_q, o_valid_d;
  logic [DATA_WIDTH-1:0] o_data_q,  o_data_d;
  logic [TAG_WIDTH-1:0]  o_tag_q,   o_tag_d;
  logic [TAG_WIDTH-1:0]  last_grant_q, last_grant_d;

  logic [TAG_WIDTH-1:0]  grant_s;
  logic                  any_req_s;
  logic                  load_en_s;
  logic                  transfer_s;
  logic [DATA_WIDTH-1:0] sel_data_s;

  dataflow_rr_select #(
    .N  (NUM_INPUTS),
    .TW (TAG_WIDTH)
  ) u_select (
    .req_i        (i_valid),
    .last_grant_i (last_grant_q),
    .grant_o      (grant_s),
    .any_req_o    (any_req_s)
  );

  // Register can take a beat when empty or being drained; reset blocks all
  // handshakes so nothing is accepted into a register that is being cleared.
  assign load_en_s  = ~reset & (~o_valid_q | o_ready);
  assign transfer_s = load_en_s & any_req_s;

  // Ready decode and payload mux for the granted requester.
  always_comb begin
    i_ready    = '0;
    sel_data_s = '0;
    for (int k = 0; k < NUM_INPUTS; k++) begin
      i_ready[k] = load_en_s & i_valid[k] & (grant_s == TAG_WIDTH'(k));
      if (grant_s == TAG_WIDTH'(k)) begin
        sel_data_s = i_data[k*DATA_WIDTH +: DATA_WIDTH];
      end else begin
        sel_data_s = sel_data_s;
      end
    end
  end

  // Next state of the output stage and the priority pointer.
  always_comb begin
    o_valid_d    = o_valid_q;
    o_data_d     = o_data_q;
    o_tag_d      = o_tag_q;
    last_grant_d = last_grant_q;
    if (transfer_s) begin
      o_valid_d    = 1'b1;
      o_data_d     = sel_data_s;
      o_tag_d      = grant_s;
      last_grant_d = grant_s;
    end else begin
      // Payload and pointer hold; only a drained beat clears valid.
      o_valid_d = o_valid_q & ~o_ready;
    end
  end

  // State registers; last_grant resets to the top index so input 0 wins first.
  always_ff @(posedge clk) begin
    if (reset) begin
      o_valid_q    <= 1'b0;
      o_data_q     <= '0;
      o_tag_q      <= '0;
      last_grant_q <= TAG_WIDTH'(NUM_INPUTS - 1);
    end else begin
      o_valid_q    <= o_valid_d;
      o_data_q     <= o_data_d;
      o_tag_q      <= o_tag_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign o_valid = o_valid_q;
  assign o_data  = o_data_q;
  assign o_tag   = o_tag_q;

endmodule

// File: tb/tb_dataflow_rr_merge.sv
module tb_dataflow_rr_merge;

  logic clk;
  int   err_cnt;
  int   chk_cnt;

  // Two-input instance
  logic        rst2;
  logic [1:0]  v2, rdy2;
  logic [63:0] d2;
  logic        ov2, ordy2;
  logic [31:0] od2;
  logic [0:0]  ot2;

  // Three-input instance
  logic        rst3;
  logic [2:0]  v3, rdy3;
  logic [95:0] d3;
  logic        ov3, ordy3;
  logic [31:0] od3;
  logic [1:0]  ot3;

  dataflow_rr_merge #(.NUM_INPUTS(2), .DATA_WIDTH(32)) dut2 (
    .clk     (clk),
    .reset   (rst2),
    .i_valid (v2),
    .i_ready (rdy2),
    .i_data  (d2),
    .o_valid (ov2),
    .o_ready (ordy2),
    .o_data  (od2),
    .o_tag   (ot2)
  );

  dataflow_rr_merge #(.NUM_INPUTS(3), .DATA_WIDTH(32)) dut3 (
    .clk     (clk),
    .reset   (rst3),
    .i_valid (v3),
    .i_ready (rdy3),
    .i_data  (d3),
    .o_valid (ov3),
    .o_ready (ordy3),
    .o_data  (od3),
    .o_tag   (ot3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    err_cnt = 0;
    chk_cnt = 0;
    rst2  = 1'b1; v2 = 2'b11; ordy2 = 1'b1;
    d2    = {32'h0000_2001, 32'h0000_1000};
    rst3  = 1'b1; v3 = 3'b000; ordy3 = 1'b1;
    d3    = {32'hC000_0002, 32'hC000_0001, 32'hC000_0000};

    // 1: reset held two cycles with both inputs valid
    tick();
    check("rst_ready_a", 64'(rdy2), 64'h0);
    check("rst_valid_a", 64'(ov2),  64'h0);
    check("rst_tag_a",   64'(ot2),  64'h0);
    tick();
    check("rst_ready_b", 64'(rdy2), 64'h0);
    check("rst_valid_b", 64'(ov2),  64'h0);
    rst2 = 1'b0;
    settle();
    check("first_grant", 64'(rdy2), 64'h1);

    // 3: both valid, full rate alternation 0,1,0,1,0,1
    for (int i = 0; i < 6; i++) begin
      tick();
      check("rr_valid", 64'(ov2), 64'h1);
      check("rr_tag",   64'(ot2), 64'(i % 2));
      check("rr_data",  64'(od2), (i % 2 == 0) ? 64'h0000_1000 : 64'h0000_2001);
      check("rr_ready", 64'(rdy2), (i % 2 == 0) ? 64'h2 : 64'h1);
    end

    // 2: single source on input 1
    v2 = 2'b10;
    d2 = {32'hA5A5_0001, 32'h0000_1000};
    settle();
    check("single_ready", 64'(rdy2), 64'h2);
    tick();
    check("single_valid", 64'(ov2), 64'h1);
    check("single_data",  64'(od2), 64'hA5A5_0001);
    check("single_tag",   64'(ot2), 64'h1);

    // 4: backpressure holds the beat and blocks all inputs
    v2 = 2'b01;
    d2 = {32'hA5A5_0001, 32'h0000_1234};
    tick();
    check("bp_load", 64'(od2), 64'h1234);
    ordy2 = 1'b0;
    v2    = 2'b11;
    d2    = {32'h6666_0001, 32'h5555_0000};
    for (int i = 0; i < 4; i++) begin
      settle();
      check("bp_ready", 64'(rdy2), 64'h0);
      tick();
      check("bp_data",  64'(od2), 64'h1234);
      check("bp_valid", 64'(ov2), 64'h1);
    end
    ordy2 = 1'b1;
    settle();
    check("bp_release_ready", 64'(rdy2), 64'h2);
    tick();
    check("bp_reload_data", 64'(od2), 64'h6666_0001);
    check("bp_reload_tag",  64'(ot2), 64'h1);

    // 5: reset while a stalled beat is held
    v2 = 2'b01;
    d2 = {32'h6666_0001, 32'h0000_DEAD};
    tick();
    check("stall_load", 64'(od2), 64'hDEAD);
    ordy2 = 1'b0;
    v2    = 2'b11;
    d2    = {32'h7777_0001, 32'h0BAD_0000};
    tick();
    check("stall_hold", 64'(od2), 64'hDEAD);
    rst2 = 1'b1;
    settle();
    check("rst_mid_ready", 64'(rdy2), 64'h0);
    tick();
    check("rst_mid_valid", 64'(ov2), 64'h0);
    rst2 = 1'b0;
    settle();
    check("rst_mid_prio", 64'(rdy2), 64'h1);
    tick();
    check("rst_mid_tag",  64'(ot2), 64'h0);
    check("rst_mid_data", 64'(od2), 64'h0BAD_0000);
    v2 = 2'b00;
    ordy2 = 1'b1;

    // 6: three inputs, 0 and 2 valid, then 1 joins
    v3 = 3'b101;
    rst3 = 1'b0;
    settle();
    check("n3_first_ready", 64'(rdy3), 64'h1);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("n3_tag",  64'(ot3), (i % 2 == 0) ? 64'h0 : 64'h2);
      check("n3_data", 64'(od3), (i % 2 == 0) ? 64'hC000_0000 : 64'hC000_0002);
    end
    v3 = 3'b111;
    tick();
    check("n3_join_a", 64'(ot3), 64'h0);
    tick();
    check("n3_join_b", 64'(ot3), 64'h1);
    check("n3_join_b_data", 64'(od3), 64'hC000_0001);
    tick();
    check("n3_join_c", 64'(ot3), 64'h2);
    // idle cycle drains and leaves priority where it was
    v3 = 3'b000;
    tick();
    check("n3_idle_valid", 64'(ov3), 64'h0);
    v3 = 3'b111;
    settle();
    check("n3_idle_prio", 64'(rdy3), 64'h1);
    tick();
    check("n3_after_idle_tag", 64'(ot3), 64'h0);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
